// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline (read/write, priority) and debug (read-only)
//   build option DMEM_ARB_DUMP_EN: enables the dump sequencer that streams every word to debug after a halt
//   ports: clk/rst (sync, active-low); i_pipe_*/o_pipe_* pipeline access; i_dbg_*/o_dbg_* debug access and dump;
//          o_mem_*/i_mem_rdata memory port (address/control combinational, read data due before the closing edge)
module dmem_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pipe_req,
  input  logic                 i_pipe_we,
  input  logic [ADDR_BITS-1:0] i_pipe_addr,
  input  logic [DATA_BITS-1:0] i_pipe_wdata,
  output logic                 o_pipe_stall,
  output logic                 o_pipe_rvalid,
  output logic [DATA_BITS-1:0] o_pipe_rdata,
  input  logic                 i_dbg_req,
  input  logic [ADDR_BITS-1:0] i_dbg_addr,
  input  logic                 i_dbg_dump,
  output logic                 o_dbg_gnt,
  output logic                 o_dbg_rvalid,
  output logic [DATA_BITS-1:0] o_dbg_rdata,
  output logic [ADDR_BITS-1:0] o_dbg_raddr,
  output logic                 o_dbg_dump_busy,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [DATA_BITS-1:0] o_mem_wdata,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [DATA_BITS-1:0] i_mem_rdata
);
`ifdef DMEM_ARB_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [ADDR_BITS-1:0] LAST = '1;
  typedef enum logic {IDLE, DUMP} state_t;
  state_t state;
  logic [ADDR_BITS-1:0] cnt;
  logic [3:0] starve;
  logic dump_start, dbg_pend, dbg_win, pipe_win;
  logic [ADDR_BITS-1:0] dbg_addr;
  always_comb begin
    dump_start = DUMP_EN && state == IDLE && i_dbg_dump;
    // a request arriving with the dump pulse waits until the dump is over
    dbg_pend = state == DUMP || (i_dbg_req && !dump_start);
    dbg_addr = state == DUMP ? cnt : i_dbg_addr;
    dbg_win = dbg_pend && (!i_pipe_req || starve == LIMIT);
    pipe_win = i_pipe_req && !dbg_win;
    o_pipe_stall = i_pipe_req && !pipe_win;
    o_dbg_gnt = dbg_win && state == IDLE;
    o_mem_addr = pipe_win ? i_pipe_addr : dbg_win ? dbg_addr : '0;
    o_mem_we = pipe_win && i_pipe_we;
    o_mem_wdata = o_mem_we ? i_pipe_wdata : '0;
    o_mem_re = (pipe_win && !i_pipe_we) || dbg_win;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      starve <= '0;
      o_pipe_rvalid <= 1'b0;
      o_pipe_rdata <= '0;
      o_dbg_rvalid <= 1'b0;
      o_dbg_rdata <= '0;
      o_dbg_raddr <= '0;
      o_dbg_dump_busy <= 1'b0;
    end else begin
      o_pipe_rvalid <= pipe_win && !i_pipe_we;
      if (pipe_win && !i_pipe_we) o_pipe_rdata <= i_mem_rdata;
      o_dbg_rvalid <= dbg_win;
      if (dbg_win) begin
        o_dbg_rdata <= i_mem_rdata;
        o_dbg_raddr <= dbg_addr;
      end
      starve <= dbg_win ? '0 : (dbg_pend && pipe_win && starve != LIMIT) ? starve + 4'd1 : starve;
      if (dump_start) begin
        state <= DUMP;
        cnt <= '0;
        o_dbg_dump_busy <= 1'b1;
      end else if (state == DUMP && dbg_win) begin
        cnt <= cnt + 1'b1;
        // busy drops together with the rvalid of the last word
        if (cnt == LAST) begin
          state <= IDLE;
          o_dbg_dump_busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and sequence checks of dmem_arbiter against a 32-word memory model
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic i_pipe_req = 1'b0, i_pipe_we = 1'b0, i_dbg_req = 1'b0, i_dbg_dump = 1'b0;
  logic [4:0] i_pipe_addr = '0, i_dbg_addr = '0;
  logic [31:0] i_pipe_wdata = '0;
  logic o_pipe_stall, o_pipe_rvalid, o_dbg_gnt, o_dbg_rvalid, o_dbg_dump_busy, o_mem_we, o_mem_re;
  logic [31:0] o_pipe_rdata, o_dbg_rdata, o_mem_wdata, i_mem_rdata;
  logic [4:0] o_dbg_raddr, o_mem_addr;
  logic [31:0] ram [32];
  logic [31:0] shadow [32];
  typedef struct {
    bit preq, pwe; int pa; logic [31:0] pd; bit dreq; int da;
    bit dump, es, eg, edr; int eda; bit eb;
  } vec_t;
  typedef struct { logic [31:0] d; int a; } dexp_t;
  logic [31:0] pq [$];
  dexp_t dq [$];
  int vecs = 0, errs = 0;
  bit exp_prv = 0, exp_drv = 0;
  logic [31:0] last_pd = '0, last_dd = '0;
  int last_da = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pipe_req(i_pipe_req), .i_pipe_we(i_pipe_we), .i_pipe_addr(i_pipe_addr), .i_pipe_wdata(i_pipe_wdata),
    .o_pipe_stall(o_pipe_stall), .o_pipe_rvalid(o_pipe_rvalid), .o_pipe_rdata(o_pipe_rdata),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr), .i_dbg_dump(i_dbg_dump),
    .o_dbg_gnt(o_dbg_gnt), .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
    .o_dbg_raddr(o_dbg_raddr), .o_dbg_dump_busy(o_dbg_dump_busy),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;
  assign i_mem_rdata = ram[o_mem_addr];
  always @(posedge clk) if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int preq, input int pwe, input int pa, input logic [31:0] pd,
                              input int dreq, input int da, input int es, input int eg,
                              input int edr, input int eda, input int eb);
    vec_t r;
    r.preq = preq != 0; r.pwe = pwe != 0; r.pa = pa; r.pd = pd;
    r.dreq = dreq != 0; r.da = da; r.dump = 1'b0;
    r.es = es != 0; r.eg = eg != 0; r.edr = edr != 0; r.eda = eda; r.eb = eb != 0;
    return r;
  endfunction

  task automatic post_edge(input bit eb);
    dexp_t e;
    chk("pipe_rvalid", 32'(o_pipe_rvalid), 32'(exp_prv));
    if (exp_prv) last_pd = pq.pop_front();
    chk("pipe_rdata", o_pipe_rdata, last_pd);
    chk("dbg_rvalid", 32'(o_dbg_rvalid), 32'(exp_drv));
    if (exp_drv) begin
      e = dq.pop_front();
      last_dd = e.d;
      last_da = e.a;
      chk("dbg_raddr", 32'(o_dbg_raddr), 32'(last_da));
    end
    chk("dbg_rdata", o_dbg_rdata, last_dd);
    chk("dump_busy", 32'(o_dbg_dump_busy), 32'(eb));
  endtask

  task automatic cycle(input vec_t v);
    i_pipe_req = v.preq; i_pipe_we = v.pwe; i_pipe_addr = v.pa[4:0]; i_pipe_wdata = v.pd;
    i_dbg_req = v.dreq; i_dbg_addr = v.da[4:0]; i_dbg_dump = v.dump;
    @(negedge clk);
    chk("pipe_stall", 32'(o_pipe_stall), 32'(v.es));
    chk("dbg_gnt", 32'(o_dbg_gnt), 32'(v.eg));
    exp_prv = v.preq && !v.pwe && !v.es;
    if (exp_prv) pq.push_back(shadow[v.pa]);
    exp_drv = v.edr;
    if (v.edr) dq.push_back('{shadow[v.eda], v.eda});
    @(posedge clk);
    if (v.preq && v.pwe && !v.es && rst) shadow[v.pa] = v.pd;
    #1;
    post_edge(v.eb);
  endtask

  task automatic run_dump(input bit hold, input int pause_at, input int abort_at);
    vec_t v;
    int cnt = 0;
    bit paused = 0;
    v = mk(0, 0, 0, 0, hold, 3, 0, 0, 0, 0, 1);
    v.dump = 1'b1;
    cycle(v);
    while (cnt < 32) begin
      if (cnt == pause_at && !paused) begin
        v = mk(1, 1, 31, 32'h55, hold, 3, 0, 0, 0, 0, 1);
        paused = 1;
      end else if (cnt == abort_at) begin
        rst = 1'b0;
        last_pd = '0;
        last_dd = '0;
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        break;
      end else begin
        v = mk(0, 0, 0, 0, hold, 3, 0, 0, 1, cnt, cnt < 31 ? 1 : 0);
        cnt++;
      end
      cycle(v);
    end
    if (hold) cycle(mk(0, 0, 0, 0, 1, 3, 0, 1, 1, 3, 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    vec_t v;
    for (int i = 0; i < 32; i++) begin
      ram[i] = 32'(i);
      shadow[i] = 32'(i);
    end
    tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 2, 0, 1, 1, 2, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 8, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 9, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 10, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 11, 0, 1, 7, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 12, 0, 1, 7, 1, 1, 1, 7, 0);
    tbl[10] = mk(1, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 31, 32'hA5A5A5A5, 1, 31, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 31, 0, 1, 1, 31, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("idle_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("idle_mem_we", 32'(o_mem_we), 32'd0);
    chk("idle_mem_re", 32'(o_mem_re), 32'd0);
    chk("idle_mem_wdata", o_mem_wdata, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 14; i++) cycle(tbl[i]);
`ifdef DMEM_ARB_DUMP_EN
    run_dump(1, -1, -1);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_dump(0, 4, -1);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_dump(0, -1, 10);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("no_dump_after_abort", 32'(o_mem_re), 32'd0);
    run_dump(0, -1, -1);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    v = mk(0, 0, 0, 0, 1, 4, 0, 1, 1, 4, 0);
    v.dump = 1'b1;
    cycle(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.dump = 1'b1;
    cycle(v);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("dump_ignored_re", 32'(o_mem_re), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
